// File: rtl/apb_stream_loader.sv
// APB3 master that streams one packed-pixel image into the recognizer register file,
// then writes the control register to start classification.
module apb_stream_loader #(
  parameter int unsigned Amba_Word       = 24,
  parameter int unsigned Amba_Addr_Depth = 13,
  parameter int unsigned File_Length     = 4096,
  parameter int unsigned Channels        = 3,
  parameter int unsigned Pixel_Width     = 8,
  parameter int unsigned Base_Addr       = 1,
  parameter int unsigned Ctrl_Addr       = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [Amba_Addr_Depth-1:0]        num_words,
  input  logic                              abort,
  input  logic                              pix_valid,
  input  logic [Channels*Pixel_Width-1:0]   pix_data,
  output logic                              pix_ready,
  output logic                              PSEL,
  output logic                              PENABLE,
  output logic                              PWRITE,
  output logic [Amba_Addr_Depth-1:0]        PADDR,
  output logic [Amba_Word-1:0]              PWDATA,
  input  logic                              PREADY,
  input  logic                              PSLVERR,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic                              aborted,
  output logic [Amba_Addr_Depth-1:0]        words_sent
);

  localparam int unsigned AW = Amba_Addr_Depth;
  localparam int unsigned DW = Amba_Word;
  localparam int unsigned PW = Channels * Pixel_Width;
  localparam logic [AW-1:0] FILE_LEN  = AW'(File_Length);
  localparam logic [AW-1:0] BASE_ADDR = AW'(Base_Addr);
  localparam logic [AW-1:0] CTRL_ADDR = AW'(Ctrl_Addr);

  // Reject parameter sets that cannot be packed or addressed.
  if (PW > DW) begin : g_bad_pack
    $error("apb_stream_loader: Channels*Pixel_Width exceeds Amba_Word");
  end
  if (Base_Addr + File_Length - 1 >= (1 << Amba_Addr_Depth)) begin : g_bad_addr
    $error("apb_stream_loader: image window exceeds APB address space");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FETCH, S_XFER, S_GO, S_FIN
  } state_t;

  state_t        state;
  logic [AW-1:0] count;
  logic          last_word_c;

  assign last_word_c = (words_sent + AW'(1)) == count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      count      <= '0;
      pix_ready  <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      aborted    <= 1'b0;
      words_sent <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            count      <= (num_words > FILE_LEN) ? FILE_LEN : num_words;
            err        <= 1'b0;
            aborted    <= 1'b0;
            words_sent <= '0;
            busy       <= 1'b1;
            PSEL       <= 1'b1;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b1;
            PADDR      <= CTRL_ADDR;
            PWDATA     <= '0;
            state      <= S_CLR;
          end
        end

        // A pixel already handshaked is always written; abort only stops an idle fetch.
        S_FETCH: begin
          if (pix_valid) begin
            pix_ready <= 1'b0;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b1;
            PADDR     <= BASE_ADDR + words_sent;
            PWDATA    <= DW'(pix_data);
            state     <= S_XFER;
          end else if (abort) begin
            pix_ready <= 1'b0;
            aborted   <= 1'b1;
            done      <= 1'b1;
            state     <= S_FIN;
          end
        end

        // Shared SETUP/ACCESS handling for the clear, image and start writes.
        S_CLR, S_XFER, S_GO: begin
          if (!PENABLE) begin
            PENABLE <= 1'b1;
          end else if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            if (state == S_XFER && !PSLVERR) begin
              words_sent <= words_sent + AW'(1);
            end
            if (PSLVERR || (abort && state != S_GO)) begin
              if (PSLVERR) err <= 1'b1;
              if (abort && state != S_GO) aborted <= 1'b1;
              done  <= 1'b1;
              state <= S_FIN;
            end else if (state == S_GO) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else if ((state == S_CLR && count == '0) ||
                         (state == S_XFER && last_word_c)) begin
              PSEL    <= 1'b1;
              PWRITE  <= 1'b1;
              PADDR   <= CTRL_ADDR;
              PWDATA  <= DW'(1);
              state   <= S_GO;
            end else begin
              pix_ready <= 1'b1;
              state     <= S_FETCH;
            end
          end
        end

        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
